// File: rtl/scrypt_sched_if.sv
// Bundle between the scrypt ROMix sequencer, the hasher front-end, the salsa pipeline and the scratchpad.
// slave = sequencer side; master = surrounding system (front-end, salsa core, RAM).
interface scrypt_sched_if #(
    parameter int unsigned ADDR_BITS = 10
);
    localparam int unsigned XW = 1024;
    localparam int unsigned HW = 512;
    localparam int unsigned XAW = 10;

    logic                 start;
    logic [XW-1:0]        data_in;
    logic                 busy;
    logic                 done;
    logic [XW-1:0]        data_out;
    logic [HW-1:0]        B;
    logic [HW-1:0]        Bx;
    logic                 feedback;
    logic [HW-1:0]        Bo;
    logic [XAW-1:0]       Xaddr;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_we;
    logic [XW-1:0]        ram_wdata;
    logic [XW-1:0]        ram_rdata;

    modport slave (
        input  start, data_in, Bo, Xaddr, ram_rdata,
        output busy, done, data_out, B, Bx, feedback, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output start, data_in, Bo, Xaddr, ram_rdata,
        input  busy, done, data_out, B, Bx, feedback, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/scrypt_sched.sv
// scrypt ROMix sequencer: BlockMix via one salsa pipeline, phase-1 scratchpad fill, phase-2 read/XOR.
// Optional SCRYPT_XADDR_PREFETCH_EN: issue the phase-2 read from the salsa early address and skip P2_READ.
module scrypt_sched #(
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned SALSA_CYCLES = 36
) (
    input  logic          clk,
    input  logic          reset_n,
    scrypt_sched_if.slave bus
);
    localparam int unsigned XW = 1024;
    localparam int unsigned HW = 512;
    localparam int unsigned CW = (SALSA_CYCLES > 1) ? $clog2(SALSA_CYCLES) : 1;
    localparam logic [CW-1:0]        CYC_LAST = CW'(SALSA_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] I_LAST   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MIX_A,
        S_MIX_B,
        S_P2_READ,
        S_P2_XOR,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [HW-1:0]        x0_q, x0_d, x1_q, x1_d;
    logic [ADDR_BITS-1:0] i_q, i_d;
    logic                 phase2_q, phase2_d;
    logic [CW-1:0]        cyc_q, cyc_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [XW-1:0]        data_out_q, data_out_d;
    logic [HW-1:0]        b_q, b_d, bx_q, bx_d;
    logic                 fb_q, fb_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic                 ram_we_q, ram_we_d;
    logic [XW-1:0]        ram_wdata_q, ram_wdata_d;

    logic                 op_last;
    state_e               p2_entry;

`ifdef SCRYPT_XADDR_PREFETCH_EN
    localparam logic [CW-1:0] CYC_PRE = CW'(SALSA_CYCLES - 2);
    logic pre_rd;
    assign p2_entry = S_P2_XOR;
    // Read issued on the final MIX_B cycle whenever a phase-2 XOR follows it
    assign pre_rd = (state_q == S_MIX_B) && (cyc_q == CYC_PRE) &&
                    (phase2_q ? (i_q != I_LAST) : (i_q == I_LAST));
`else
    assign p2_entry = S_P2_READ;
`endif

    assign op_last = (cyc_q == CYC_LAST);

    // Next-state, datapath and look-ahead output computation
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        i_d         = i_q;
        phase2_d    = phase2_q;
        cyc_d       = cyc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        data_out_d  = data_out_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x0_d     = bus.data_in[HW-1:0];
                    x1_d     = bus.data_in[XW-1:HW];
                    i_d      = '0;
                    phase2_d = 1'b0;
                    cyc_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_MIX_A;
                end
            end
            S_MIX_A: begin
                cyc_d = cyc_q + CW'(1);
                if (op_last) begin
                    x0_d    = bus.Bo;
                    cyc_d   = '0;
                    state_d = S_MIX_B;
                end
            end
            S_MIX_B: begin
                cyc_d = cyc_q + CW'(1);
                if (op_last) begin
                    x1_d  = bus.Bo;
                    cyc_d = '0;
                    if (!phase2_q) begin
                        if (i_q == I_LAST) begin
                            i_d      = '0;
                            phase2_d = 1'b1;
                            state_d  = p2_entry;
                        end else begin
                            i_d     = i_q + ADDR_BITS'(1);
                            state_d = S_MIX_A;
                        end
                    end else if (i_q == I_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + ADDR_BITS'(1);
                        state_d = p2_entry;
                    end
                end
            end
            S_P2_READ: state_d = S_P2_XOR;
            S_P2_XOR: begin
                x0_d    = x0_q ^ bus.ram_rdata[HW-1:0];
                x1_d    = x1_q ^ bus.ram_rdata[XW-1:HW];
                cyc_d   = '0;
                state_d = S_MIX_A;
            end
            S_DONE: begin
                data_out_d = {x1_q, x0_q};
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Salsa operands follow the state being entered so they are stable for the whole op
        b_d  = (state_d == S_MIX_B) ? x1_d : x0_d;
        bx_d = (state_d == S_MIX_B) ? x0_d : x1_d;
        fb_d = ((state_d == S_MIX_A) || (state_d == S_MIX_B)) && (cyc_d != '0);

        ram_we_d = (state_d == S_MIX_A) && (cyc_d == '0) && !phase2_d;
        if (ram_we_d) begin
            ram_addr_d  = i_d;
            ram_wdata_d = {x1_d, x0_d};
`ifdef SCRYPT_XADDR_PREFETCH_EN
        end else if (pre_rd) begin
            ram_addr_d = bus.Xaddr[ADDR_BITS-1:0];
`else
        end else if (state_d == S_P2_READ) begin
            ram_addr_d = x1_d[ADDR_BITS-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            i_q         <= '0;
            phase2_q    <= 1'b0;
            cyc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= '0;
            b_q         <= '0;
            bx_q        <= '0;
            fb_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            i_q         <= i_d;
            phase2_q    <= phase2_d;
            cyc_q       <= cyc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            data_out_q  <= data_out_d;
            b_q         <= b_d;
            bx_q        <= bx_d;
            fb_q        <= fb_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.data_out  = data_out_q;
    assign bus.B         = b_q;
    assign bus.Bx        = bx_q;
    assign bus.feedback  = fb_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_scrypt_sched.sv
// Directed bench for scrypt_sched with ADDR_BITS=2: salsa20/8 pipeline model, 1-cycle RAM, reference ROMix.
module tb_scrypt_sched;
    localparam int unsigned AB  = 2;
    localparam int unsigned N   = 1 << AB;
    localparam int unsigned SC  = 36;
`ifdef SCRYPT_XADDR_PREFETCH_EN
    localparam int LAT     = 581;
    localparam int FB0_EXP = 21;
`else
    localparam int LAT     = 585;
    localparam int FB0_EXP = 25;
`endif
    localparam logic [511:0] GARB = {16{32'hDEAD_BEEF}};

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    scrypt_sched_if #(.ADDR_BITS(AB)) bus ();
    scrypt_sched #(.ADDR_BITS(AB), .SALSA_CYCLES(SC)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int total = 0;
    int bad = 0;

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] salsa8(input logic [511:0] b);
        logic [31:0] x [16];
        logic [31:0] w [16];
        logic [511:0] o;
        for (int k = 0; k < 16; k++) begin w[k] = b[32*k +: 32]; x[k] = w[k]; end
        for (int r = 0; r < 4; r++) begin
            x[4]  ^= rl(x[0]  + x[12], 7);  x[8]  ^= rl(x[4]  + x[0],  9);
            x[12] ^= rl(x[8]  + x[4], 13);  x[0]  ^= rl(x[12] + x[8], 18);
            x[9]  ^= rl(x[5]  + x[1],  7);  x[13] ^= rl(x[9]  + x[5],  9);
            x[1]  ^= rl(x[13] + x[9], 13);  x[5]  ^= rl(x[1]  + x[13], 18);
            x[14] ^= rl(x[10] + x[6],  7);  x[2]  ^= rl(x[14] + x[10], 9);
            x[6]  ^= rl(x[2]  + x[14], 13); x[10] ^= rl(x[6]  + x[2], 18);
            x[3]  ^= rl(x[15] + x[11], 7);  x[7]  ^= rl(x[3]  + x[15], 9);
            x[11] ^= rl(x[7]  + x[3], 13);  x[15] ^= rl(x[11] + x[7], 18);
            x[1]  ^= rl(x[0]  + x[3],  7);  x[2]  ^= rl(x[1]  + x[0],  9);
            x[3]  ^= rl(x[2]  + x[1], 13);  x[0]  ^= rl(x[3]  + x[2], 18);
            x[6]  ^= rl(x[5]  + x[4],  7);  x[7]  ^= rl(x[6]  + x[5],  9);
            x[4]  ^= rl(x[7]  + x[6], 13);  x[5]  ^= rl(x[4]  + x[7], 18);
            x[11] ^= rl(x[10] + x[9],  7);  x[8]  ^= rl(x[11] + x[10], 9);
            x[9]  ^= rl(x[8]  + x[11], 13); x[10] ^= rl(x[9]  + x[8], 18);
            x[12] ^= rl(x[15] + x[14], 7);  x[13] ^= rl(x[12] + x[15], 9);
            x[14] ^= rl(x[13] + x[12], 13); x[15] ^= rl(x[14] + x[13], 18);
        end
        for (int k = 0; k < 16; k++) o[32*k +: 32] = x[k] + w[k];
        return o;
    endfunction

    function automatic logic [1023:0] bmix(input logic [1023:0] x);
        logic [511:0] lo, hi;
        lo = salsa8(x[511:0] ^ x[1023:512]);
        hi = salsa8(x[1023:512] ^ lo);
        return {hi, lo};
    endfunction

    logic [1023:0] vref [N];
    logic [AB-1:0] jref [N];

    task automatic ref_romix(input logic [1023:0] din, output logic [1023:0] dout);
        logic [1023:0] x;
        x = din;
        for (int k = 0; k < N; k++) begin vref[k] = x; x = bmix(x); end
        for (int k = 0; k < N; k++) begin
            jref[k] = x[512 +: AB];
            x = bmix(x ^ vref[jref[k]]);
        end
        dout = x;
    endtask

    // Salsa pipeline: result of an op's first-cycle operands appears on Bo in its last cycle
    logic [511:0] pipe [35] = '{default: '0};
    logic [511:0] nxt_in = '0;
    always @(posedge clk) begin
        for (int k = 34; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= nxt_in;
    end
    assign bus.Bo    = pipe[34];
    assign bus.Xaddr = pipe[33][9:0];

    logic [1023:0] mem [N] = '{default: '0};
    logic          r_we = 1'b0;
    logic [AB-1:0] r_addr = '0;
    logic [1023:0] r_wdata = '0;
    always @(posedge clk) begin
        if (r_we) mem[r_addr] <= r_wdata;
        bus.ram_rdata <= mem[r_addr];
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int done_cnt, done_edge, fb0_cnt, fb_tr, we_idle;
    logic fb_h1, fb_h2;
    logic [AB-1:0] a_h1, a_h2;
    int wr_addr [$];
    int wr_edge [$];
    logic [1023:0] wr_data [$];
    int rd_addr [$];

    always @(negedge clk) begin
        nxt_in = bus.feedback ? GARB : salsa8(bus.B ^ bus.Bx);
        r_we = bus.ram_we; r_addr = bus.ram_addr; r_wdata = bus.ram_wdata;
        if (bus.done) begin done_cnt++; done_edge = edge_cnt; end
        if (bus.ram_we) begin
            wr_addr.push_back(int'(bus.ram_addr));
            wr_edge.push_back(edge_cnt);
            wr_data.push_back(bus.ram_wdata);
            if (!bus.busy) we_idle++;
        end
        if (bus.busy) begin
            if (!bus.feedback) fb0_cnt++;
            if (bus.feedback != fb_h1) fb_tr++;
`ifdef SCRYPT_XADDR_PREFETCH_EN
            if (fb_h2 && !fb_h1 && !bus.feedback) rd_addr.push_back(int'(a_h2));
`else
            if (fb_h2 && !fb_h1 && !bus.feedback) rd_addr.push_back(int'(a_h1));
`endif
        end
        fb_h2 = fb_h1; fb_h1 = bus.feedback;
        a_h2 = a_h1;   a_h1 = bus.ram_addr;
    end

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int st_edge;

    task automatic launch(input logic [1023:0] din);
        done_cnt = 0; done_edge = -1; fb0_cnt = 0; fb_tr = 0; we_idle = 0;
        fb_h1 = 1'b0; fb_h2 = 1'b0;
        wr_addr.delete(); wr_edge.delete(); wr_data.delete(); rd_addr.delete();
        bus.data_in = din;
        bus.start   = 1'b1;
        st_edge     = edge_cnt + 1;
        tick();
        bus.start   = 1'b0;
        bus.data_in = ~din;
    endtask

    task automatic wait_done(input int spur_at);
        for (int k = 1; k < 3000 && done_cnt == 0; k++) begin
            if (k == spur_at) bus.start = 1'b1;
            if (k == 50) check("busy_mid", 1024'(bus.busy), 1024'(1));
            tick();
            bus.start = 1'b0;
        end
        check("done_seen", 1024'(done_cnt), 1024'(1));
    endtask

    task automatic check_run(input string tag, input logic [1023:0] exp);
        check({tag, "_latency"}, 1024'(done_edge - st_edge), 1024'(LAT));
        check({tag, "_busy_at_done"}, 1024'(bus.busy), 1024'(0));
        check({tag, "_data_out"}, bus.data_out, exp);
        repeat (4) tick();
        check({tag, "_one_done"}, 1024'(done_cnt), 1024'(1));
        check({tag, "_data_held"}, bus.data_out, exp);
        check({tag, "_n_writes"}, 1024'(wr_addr.size()), 1024'(N));
        check({tag, "_we_idle"}, 1024'(we_idle), 1024'(0));
        check({tag, "_fb_low_cycles"}, 1024'(fb0_cnt), 1024'(FB0_EXP));
        check({tag, "_fb_transitions"}, 1024'(fb_tr), 1024'(8 * N));
        check({tag, "_n_reads"}, 1024'(rd_addr.size()), 1024'(N));
        for (int k = 0; k < N && k < wr_addr.size(); k++) begin
            check($sformatf("%s_wr_addr%0d", tag, k), 1024'(wr_addr[k]), 1024'(k));
            check($sformatf("%s_wr_edge%0d", tag, k), 1024'(wr_edge[k] - st_edge), 1024'(72 * k));
            check($sformatf("%s_wr_data%0d", tag, k), wr_data[k], vref[k]);
        end
        for (int k = 0; k < N && k < rd_addr.size(); k++)
            check($sformatf("%s_rd_addr%0d", tag, k), 1024'(rd_addr[k]), 1024'(jref[k]));
    endtask

    logic [1023:0] d1, d2, e1, e2;

    initial begin
        bus.start   = 1'b0;
        bus.data_in = '0;
        d1 = {8{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};
        d2 = {16{64'hF0E1_D2C3_B4A5_9687}} ^ {32{32'h0000_0003}};

        #3 reset_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", 1024'(bus.busy), 1024'(0));
        check("rst_done", 1024'(bus.done), 1024'(0));
        check("rst_we", 1024'(bus.ram_we), 1024'(0));
        check("rst_fb", 1024'(bus.feedback), 1024'(0));
        check("rst_data_out", bus.data_out, 1024'(0));
        check("rst_B", 1024'(bus.B), 1024'(0));
        reset_n = 1'b1;
        repeat (2) tick();

        // Run 1: spurious start while busy must be ignored
        ref_romix(d1, e1);
        launch(d1);
        wait_done(100);
        check_run("run1", e1);

        // Run 2: aborted by reset mid-operation
        launch(d2);
        repeat (300) tick();
        reset_n = 1'b0;
        #1;
        check("abort_busy", 1024'(bus.busy), 1024'(0));
        check("abort_done", 1024'(bus.done), 1024'(0));
        check("abort_we", 1024'(bus.ram_we), 1024'(0));
        check("abort_fb", 1024'(bus.feedback), 1024'(0));
        check("abort_data_out", bus.data_out, 1024'(0));
        tick();
        reset_n = 1'b1;
        check("abort_no_done", 1024'(done_cnt), 1024'(0));
        repeat (2) tick();

        // Run 3: fresh start after reset release, full latency
        ref_romix(d2, e2);
        launch(d2);
        wait_done(0);
        check_run("run3", e2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scrypt_sched.md
Name: scrypt_sched

Overview:
- Sequencer driving one salsa pipeline through the full scrypt ROMix loop: BlockMix, scratchpad write (phase 1), then scratchpad read plus XOR (phase 2).
- Owns the 1024-bit X state, the iteration counter and the scratchpad RAM port.
- Presents B/Bx/feedback to the salsa pipeline and consumes its Bo/Xaddr outputs.
- Sits between the hasher front-end (PBKDF2 input/output) and the salsa core.

Parameters:
- ADDR_BITS, 10, scratchpad index width; N = 2**ADDR_BITS iterations per phase.
- SALSA_CYCLES, 36, cycles per salsa20/8 operation in the pipeline.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- data_in  in  1024  initial X; [511:0]=X0, [1023:512]=X1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the result is valid.
- data_out  out  1024  final X, held until the next start.
- B  out  512  salsa input (first operand).
- Bx  out  512  salsa input (second operand).
- feedback  out  1  salsa recirculate select.
- Bo  in  512  salsa result, valid on the last cycle of an op.
- Xaddr  in  10  salsa early address, valid one cycle before Bo.
- ram_addr  out  ADDR_BITS  scratchpad address.
- ram_we  out  1  write strobe.
- ram_wdata  out  1024  write data {X1,X0}.
- ram_rdata  in  1024  read data, 1-cycle latency after address.

Behaviour:
- Reset: state IDLE; busy=0, done=0, data_out=0, feedback=0, ram_we=0, counter=0, X=0.
- States: IDLE, MIX_A, MIX_B, P2_READ, P2_XOR, DONE.
- IDLE + start: X<=data_in, phase=1, i=0, go to MIX_A.
- MIX_A: lasts SALSA_CYCLES cycles.
  - B=X0, Bx=X1.
  - feedback=0 on the first cycle, 1 on all later cycles.
  - Last cycle: X0<=Bo.
  - Phase 1 only: on the first cycle, ram_we=1, ram_addr=i, ram_wdata={X1,X0}, using X as it was before the mix.
- MIX_B: same timing as MIX_A, with B=X1 and Bx=X0 (the new X0). Last cycle: X1<=Bo.
  - Phase 1, i<N-1: i++, go to MIX_A.
  - Phase 1, i=N-1: i=0, phase=2, go to P2_READ.
  - Phase 2, i<N-1: i++, go to P2_READ.
  - Phase 2, i=N-1: go to DONE.
- P2_READ: ram_addr=X1[ADDR_BITS-1:0], ram_we=0, 1 cycle.
- P2_XOR: X0^=ram_rdata[511:0], X1^=ram_rdata[1023:512], then MIX_A; 1 cycle.
- DONE: data_out<=X, done=1 for 1 cycle, busy falls, return to IDLE.
- Iteration timing: phase-1 iteration = 2*SALSA_CYCLES = 72 cycles; phase-2 iteration = 74 cycles.
- Latency: done asserts exactly 1 + N*72 + N*74 cycles after the start sample edge.
- start while busy: ignored, with no state change.
- ram_we: never asserted in phase 2 or in IDLE.
- Address wrap: counter i is ADDR_BITS wide; terminal compare at N-1 with no overflow; read index uses the low ADDR_BITS of X1 word 0.
- reset_n low mid-operation: immediate return to reset values, with no partial done.

Optional Feature:
- Macro: SCRYPT_XADDR_PREFETCH_EN.
- Defined:
  - The scratchpad read address is taken from Xaddr[ADDR_BITS-1:0] and issued on the last cycle of every MIX_B that is followed by phase-2 work, including the final phase-1 MIX_B.
  - P2_READ is skipped: MIX_B goes directly to P2_XOR.
  - Phase-2 iteration = 73 cycles; total latency 1 + N*72 + N*73.
- Undefined: Xaddr is unused (left unconnected internally) and the P2_READ path applies.

Test Plan:
- ADDR_BITS=2, salsa model, data_in = scrypt test vector X -> data_out matches the C reference ROMix; done at cycle 585 (581 with prefetch); exactly one done pulse.
- Phase 1, N=4 -> ram_we pulses 4 times at addresses 0,1,2,3, spaced 72 cycles apart; each ram_wdata equals the pre-mix X; no writes after phase 2 starts.
- Phase 2 -> each ram_addr equals X1[1:0] after the preceding MIX_B; with prefetch, Xaddr equals that same value one cycle before Bo.
- start pulsed at cycle 100 while busy -> no restart; done cycle and data_out unchanged.
- reset_n dropped at cycle 300 -> busy=0, done=0, ram_we=0 asynchronously; a new start after release yields a correct result at full latency.
- feedback check -> low exactly on the first cycle of each 36-cycle op, 8 transitions per iteration pair; Bo captured only on op last cycles.
